ahb3lite_interconnect_arbiter: RTL

AHB3LITE_INTERCONNECT_ARBITER -- requirements
Module: ahb3lite_interconnect_arbiter

---
 rtl/ahb3lite_pkg.sv | 67 ++++++
 rtl/ahb3lite_interconnect_arb_select.sv | 31 +++
 rtl/ahb3lite_interconnect_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite constants plus the arbiter state type and the
// priority/round-robin winner search used by every slave-port arbiter.
package ahb3lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Search tables are sized for the largest legal port count
   localparam int ARB_MAX_MASTERS = 16;
   localparam int ARB_IDX_BITS    = 4;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic                    valid;
      logic [ARB_IDX_BITS-1:0] idx;
   } arb_sel_t;

   // Highest priority among requesters wins; ties go to the first
   // requester found searching upward from rr_ptr+1, wrapping at n-1.
   function automatic arb_sel_t arb_select(
      input logic [ARB_MAX_MASTERS-1:0]                   req,
      input logic [ARB_MAX_MASTERS-1:0][ARB_IDX_BITS-1:0] prio,
      input logic [ARB_IDX_BITS-1:0]                      rr_ptr,
      input int                                           n
   );
      arb_sel_t                r;
      logic [ARB_IDX_BITS-1:0] best;
      logic [ARB_IDX_BITS:0]   sum;
      logic [ARB_IDX_BITS-1:0] idx;
      r    = '0;
      best = '0;
      for (int i = 0; i < ARB_MAX_MASTERS; i++) begin
         if (i < n && req[4'(i)] && prio[4'(i)] > best)
            best = prio[4'(i)];
      end
      for (int k = 1; k <= ARB_MAX_MASTERS; k++) begin
         sum = {1'b0, rr_ptr} + 5'(k);
         if (sum >= 5'(n))
            sum = sum - 5'(n);
         idx = sum[ARB_IDX_BITS-1:0];
         if (k <= n && !r.valid && req[idx] && prio[idx] == best) begin
            r.valid = 1'b1;
            r.idx   = idx;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ahb3lite_interconnect_arb_select.sv
// Combinational winner selector for one slave port; pads the port-sized
// request/priority vectors out to the package search function.
module ahb3lite_interconnect_arb_select
   import ahb3lite_pkg::*;
#(
   parameter int MASTERS     = 3,
   parameter int MASTER_BITS = $clog2(MASTERS)
) (
   input  logic [MASTERS-1:0]                  i_req,
   input  logic [MASTERS-1:0][MASTER_BITS-1:0] i_prio,
   input  logic [MASTER_BITS-1:0]              i_rr_ptr,
   output logic [MASTER_BITS-1:0]              o_idx,
   output logic                                o_valid
);

   logic [ARB_MAX_MASTERS-1:0]                   w_req;
   logic [ARB_MAX_MASTERS-1:0][ARB_IDX_BITS-1:0] w_prio;
   arb_sel_t                                     w_sel;

   always_comb begin
      w_req  = ARB_MAX_MASTERS'(i_req);
      w_prio = '0;
      for (int i = 0; i < MASTERS; i++)
         w_prio[i] = ARB_IDX_BITS'(i_prio[i]);
      w_sel  = arb_select(w_req, w_prio, ARB_IDX_BITS'(i_rr_ptr), MASTERS);
   end

   assign o_idx   = w_sel.idx[MASTER_BITS-1:0];
   assign o_valid = w_sel.valid && (int'(w_sel.idx) < MASTERS);

endmodule

// File: rtl/ahb3lite_interconnect_arbiter.sv
// Slave-port arbiter: priority + round-robin grant, owner held until it
// signals a switch point with HREADY high; tracks the data-phase owner.
module ahb3lite_interconnect_arbiter
   import ahb3lite_pkg::*;
#(
   parameter int MASTERS     = 3,
   parameter int MASTER_BITS = $clog2(MASTERS)
) (
   input  logic                                HCLK,
   input  logic                                HRESET,
   input  logic [MASTERS-1:0]                  mst_HSEL,
   input  logic [MASTERS-1:0][MASTER_BITS-1:0] mst_priority,
   input  logic [MASTERS-1:0]                  mst_can_switch,
   input  logic                                slv_HREADY,
   output logic [MASTERS-1:0]                  master_granted,
   output logic [MASTER_BITS-1:0]              granted_master,
   output logic [MASTER_BITS-1:0]              dataphase_master,
   output logic                                dataphase_valid
);

   arb_state_e             r_state, w_state_nxt;
   logic [MASTERS-1:0]     r_grant, w_grant_nxt;
   logic [MASTER_BITS-1:0] r_gidx, w_gidx_nxt;
   logic [MASTER_BITS-1:0] r_rr_ptr, w_rr_nxt;
   logic [MASTER_BITS-1:0] r_dp_master;
   logic                   r_dp_valid;
   logic [MASTER_BITS-1:0] w_sel_idx;
   logic                   w_sel_valid;
   logic                   w_rearb;

   ahb3lite_interconnect_arb_select #(
      .MASTERS     (MASTERS),
      .MASTER_BITS (MASTER_BITS)
   ) u_select (
      .i_req    (mst_HSEL),
      .i_prio   (mst_priority),
      .i_rr_ptr (r_rr_ptr),
      .o_idx    (w_sel_idx),
      .o_valid  (w_sel_valid)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_gidx_nxt  = r_gidx;
      w_rr_nxt    = r_rr_ptr;
      w_rearb     = 1'b1;
      case (r_state)
         ARB_IDLE:  w_rearb = 1'b1;
         // No pre-emption: locked transfers and bursts finish on one owner
         ARB_OWNED: w_rearb = mst_can_switch[r_gidx] && slv_HREADY;
         default:   w_rearb = 1'b1;
      endcase
      if (w_rearb) begin
         if (w_sel_valid) begin
            w_state_nxt            = ARB_OWNED;
            w_gidx_nxt             = w_sel_idx;
            w_rr_nxt               = w_sel_idx;
            w_grant_nxt            = '0;
            w_grant_nxt[w_sel_idx] = 1'b1;
         end else begin
            w_state_nxt = ARB_IDLE;
            w_gidx_nxt  = '0;
            w_grant_nxt = '0;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state     <= ARB_IDLE;
         r_grant     <= '0;
         r_gidx      <= '0;
         r_rr_ptr    <= MASTER_BITS'(MASTERS - 1);
         r_dp_master <= '0;
         r_dp_valid  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_gidx   <= w_gidx_nxt;
         r_rr_ptr <= w_rr_nxt;
         // Data phase follows the address phase only when the slave advances
         if (slv_HREADY) begin
            r_dp_master <= r_gidx;
            r_dp_valid  <= (r_state == ARB_OWNED);
         end
      end
   end

   assign master_granted   = r_grant;
   assign granted_master   = r_gidx;
   assign dataphase_master = r_dp_master;
   assign dataphase_valid  = r_dp_valid;

endmodule
